// File: rtl/eq_pkg.sv
// ============================================================================
// Module : eq_pkg
// Brief  : Shared types and constants for the equalizer pot scan controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } scan_state_t;

  localparam int NUM_POTS = 6;

  // Scan slot -> ADC128S channel; the board wiring is not in channel order.
  localparam logic [2:0] CH_MAP [NUM_POTS] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};

  localparam logic [2:0] POT_LP_IDX = 3'd0;
  localparam logic [2:0] POT_B1_IDX = 3'd1;
  localparam logic [2:0] POT_B2_IDX = 3'd2;
  localparam logic [2:0] POT_B3_IDX = 3'd3;
  localparam logic [2:0] POT_HP_IDX = 3'd4;
  localparam logic [2:0] VOLUME_IDX = 3'd5;

  function automatic logic [2:0] chnl_of(input logic [2:0] idx);
    if (idx < 3'(NUM_POTS)) begin
      chnl_of = CH_MAP[idx];
    end else begin
      chnl_of = CH_MAP[0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/pot_scan_ctrl_if.sv
// ============================================================================
// Module : pot_scan_ctrl_if
// Brief  : strt_cnv/cnv_cmplt handshake between scan controller and SPI A2D.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pot_scan_ctrl_if;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (
    output strt_cnv,
    output chnnl,
    input  cnv_cmplt,
    input  res
  );

  modport slave (
    input  strt_cnv,
    input  chnnl,
    output cnv_cmplt,
    output res
  );
endinterface

`default_nettype wire

// File: rtl/pot_timer.sv
// ============================================================================
// Module : pot_timer
// Brief  : Clearable up-counter with terminal-count compare.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pot_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
    if (clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

`default_nettype wire

// File: rtl/pot_scan_ctrl.sv
// ============================================================================
// Module : pot_scan_ctrl
// Brief  : Round-robin A2D sequencer for the six equalizer pots with IIR smoothing.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pot_scan_ctrl
  import eq_pkg::*;
#(
  parameter int SCAN_GAP = 1024,
  parameter int TIMEOUT  = 4096,
  parameter int SMOOTH   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  pot_scan_ctrl_if.master        a2d,
  output logic [11:0]            POT_LP,
  output logic [11:0]            POT_B1,
  output logic [11:0]            POT_B2,
  output logic [11:0]            POT_B3,
  output logic [11:0]            POT_HP,
  output logic [11:0]            VOLUME,
  output logic                   scan_done,
  output logic                   err
);

  localparam int TMR_MAX = (TIMEOUT > SCAN_GAP) ? TIMEOUT : SCAN_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  scan_state_t         state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic                err_q, err_d;
  logic                scan_done_q, scan_done_d;
  logic [11:0]         pot_q [NUM_POTS];
  logic [11:0]         pot_d [NUM_POTS];
  logic [NUM_POTS-1:0] seen_q, seen_d;

  logic                upd;
  logic                adv;
  logic                tmr_clr;
  logic                tmr_tc;
  logic [TMR_W-1:0]    tmr_tc_val;

  logic [11:0]         cur_pot;
  logic [11:0]         new_pot;
  logic signed [12:0]  diff;
  logic signed [12:0]  step;

  // One timer serves both WAIT timeout and GAP length; every state entry restarts it.
  assign tmr_clr    = (state_d != state_q);
  assign tmr_tc_val = (state_q == GAP) ? TMR_W'(SCAN_GAP - 1) : TMR_W'(TIMEOUT - 1);

  pot_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .tc_val (tmr_tc_val),
    .tc     (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    scan_done_d = 1'b0;
    upd         = 1'b0;
    adv         = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A completion on the terminal-count cycle wins over the timeout.
        if (a2d.cnv_cmplt) begin
          upd = 1'b1;
          adv = 1'b1;
        end else if (tmr_tc) begin
          err_d = 1'b1;
          adv   = 1'b1;
        end
        if (adv) begin
          if (idx_q == VOLUME_IDX) begin
            scan_done_d = 1'b1;
            state_d     = GAP;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = START;
          end
        end
      end
      GAP: begin
        if (tmr_tc) begin
          if (en) begin
            idx_d   = '0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    cur_pot = pot_q[idx_q];
    diff    = $signed({1'b0, a2d.res}) - $signed({1'b0, cur_pot});
    step    = diff >>> SMOOTH;
    new_pot = seen_q[idx_q] ? (cur_pot + step[11:0]) : a2d.res;
    seen_d  = seen_q;
    for (int i = 0; i < NUM_POTS; i++) begin
      pot_d[i] = pot_q[i];
      if (upd && (idx_q == 3'(i))) begin
        pot_d[i]  = new_pot;
        seen_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      err_q       <= 1'b0;
      scan_done_q <= 1'b0;
      seen_q      <= '0;
      for (int i = 0; i < NUM_POTS; i++) begin
        pot_q[i] <= 12'h000;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      scan_done_q <= scan_done_d;
      seen_q      <= seen_d;
      for (int i = 0; i < NUM_POTS; i++) begin
        pot_q[i] <= pot_d[i];
      end
    end
  end

  assign a2d.strt_cnv = (state_q == START);
  assign a2d.chnnl    = chnl_of(idx_q);

  assign POT_LP    = pot_q[POT_LP_IDX];
  assign POT_B1    = pot_q[POT_B1_IDX];
  assign POT_B2    = pot_q[POT_B2_IDX];
  assign POT_B3    = pot_q[POT_B3_IDX];
  assign POT_HP    = pot_q[POT_HP_IDX];
  assign VOLUME    = pot_q[VOLUME_IDX];
  assign scan_done = scan_done_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pot_scan_ctrl.sv
// ============================================================================
// Module : tb_pot_scan_ctrl
// Brief  : Self-checking bench: A2D transactor model plus pot reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pot_scan_ctrl;

  localparam int SCAN_GAP = 64;
  localparam int TIMEOUT  = 128;
  localparam int SMOOTH   = 2;
  localparam int DIV      = 4;
  localparam int SCAN_BUDGET = 6 * (TIMEOUT + 2) + SCAN_GAP + 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, volume;
  logic        scan_done, err;
  logic [11:0] pots [6];

  always #10 clk = ~clk;

  pot_scan_ctrl_if a2d ();

  pot_scan_ctrl #(
    .SCAN_GAP (SCAN_GAP),
    .TIMEOUT  (TIMEOUT),
    .SMOOTH   (SMOOTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .a2d       (a2d),
    .POT_LP    (pot_lp),
    .POT_B1    (pot_b1),
    .POT_B2    (pot_b2),
    .POT_B3    (pot_b3),
    .POT_HP    (pot_hp),
    .VOLUME    (volume),
    .scan_done (scan_done),
    .err       (err)
  );

  assign pots[0] = pot_lp;
  assign pots[1] = pot_b1;
  assign pots[2] = pot_b2;
  assign pots[3] = pot_b3;
  assign pots[4] = pot_hp;
  assign pots[5] = volume;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int ch_tab [6] = '{1, 0, 4, 2, 3, 7};

  always @(posedge clk) cyc <= cyc + 1;

  // Transactor knobs, written only by the test sequence.
  int          base_lat  = 40;
  int          term_ch   = -1;
  logic [7:0]  drop_mask = 8'h00;
  int          vmode     = 0;
  logic [11:0] lp_vals [3];
  int          lp_cnt    = 0;
  int          spur_cnt  = 0;

  // Transactor and reference-model state, owned by the transactor process.
  logic        pend = 1'b0;
  logic        p_stale = 1'b0;
  int          p_cnt, p_ch;
  logic [11:0] p_val;
  int          lp_n = 0;
  int          spur_done = 0;
  int          exp_pot [6];
  logic        exp_seen [6];
  logic        exp_err = 1'b0;

  function automatic int idx_of(input int ch);
    for (int i = 0; i < 6; i++) if (ch_tab[i] == ch) return i;
    return 0;
  endfunction

  function automatic void model_apply(input int ch, input logic [11:0] v);
    int i, d, st;
    i = idx_of(ch);
    if (!exp_seen[i]) begin
      exp_pot[i] = int'(v);
    end else begin
      d  = int'(v) - exp_pot[i];
      st = (d >= 0) ? (d / DIV) : -((-d + DIV - 1) / DIV);
      exp_pot[i] = (exp_pot[i] + st) % 4096;
    end
    exp_seen[i] = 1'b1;
  endfunction

  initial begin
    int ch;
    a2d.cnv_cmplt = 1'b0;
    a2d.res       = 12'h000;
    for (int i = 0; i < 6; i++) begin exp_pot[i] = 0; exp_seen[i] = 1'b0; end
    forever begin
      @(negedge clk);
      a2d.cnv_cmplt = 1'b0;
      if (rst) begin
        p_stale = 1'b1;
        lp_n    = 0;
        exp_err = 1'b0;
        for (int i = 0; i < 6; i++) begin exp_pot[i] = 0; exp_seen[i] = 1'b0; end
      end
      if (pend) begin
        p_cnt--;
        if (p_cnt == 0) begin
          a2d.cnv_cmplt = 1'b1;
          a2d.res       = p_val;
          pend          = 1'b0;
          if (!p_stale) model_apply(p_ch, p_val);
        end
      end else if (spur_cnt != spur_done) begin
        spur_done++;
        a2d.cnv_cmplt = 1'b1;
        a2d.res       = 12'($urandom);
      end
      if (a2d.strt_cnv && !rst) begin
        ch = int'(a2d.chnnl);
        if (drop_mask[ch]) begin
          exp_err = 1'b1;
        end else begin
          pend    = 1'b1;
          p_stale = 1'b0;
          p_ch    = ch;
          if (ch == term_ch) p_cnt = TIMEOUT;
          else if (base_lat > 0) p_cnt = base_lat;
          else p_cnt = int'($urandom_range(60, 1));
          if (vmode == 1) begin
            p_val = 12'(32'h111 * (idx_of(ch) + 1));
          end else if (ch == 1 && lp_n < lp_cnt) begin
            p_val = lp_vals[lp_n];
            lp_n++;
          end else begin
            p_val = 12'($urandom);
          end
        end
      end
    end
  end

  // Monitor: log every strt_cnv with its channel and cycle, count scan_done pulses.
  int st_ch [$];
  int st_cyc [$];
  int sd_cnt = 0;
  int sd_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        st_ch.delete();
        st_cyc.delete();
        sd_cnt = 0;
      end else begin
        if (a2d.strt_cnv) begin
          st_ch.push_back(int'(a2d.chnnl));
          st_cyc.push_back(cyc);
        end
        if (scan_done) begin
          sd_cnt++;
          sd_cyc = cyc;
        end
      end
    end
  end

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 300 && pend; k++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_sd(input int n, output bit ok);
    int k = 0;
    while (sd_cnt < n && k < SCAN_BUDGET) begin @(negedge clk); k++; end
    ok = (sd_cnt >= n);
  endtask

  task automatic wait_starts(input int n, output bit ok);
    int k = 0;
    while (st_ch.size() < n && k < SCAN_BUDGET) begin @(negedge clk); k++; end
    ok = (st_ch.size() >= n);
  endtask

  task automatic test_reset();
    en  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (a2d.strt_cnv !== 1'b0) begin n_fail++; $display("FAIL rst_strt: got %b want 0", a2d.strt_cnv); end
    n_cmp++; if (a2d.chnnl !== 3'd1) begin n_fail++; $display("FAIL rst_chnnl: got %0d want 1", a2d.chnnl); end
    n_cmp++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL rst_scan_done: got %b want 0", scan_done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (pots[i] !== 12'h000) begin n_fail++; $display("FAIL rst_pot%0d: got %h want 000", i, pots[i]); end
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (a2d.strt_cnv !== 1'b0) begin n_fail++; $display("FAIL idle_strt: got %b want 0", a2d.strt_cnv); end
  endtask

  task automatic test_basic_scan();
    bit ok;
    int t_en;
    logic [11:0] want;
    do_reset();
    vmode = 1; base_lat = 40; term_ch = -1; drop_mask = 8'h00; lp_cnt = 0;
    en   = 1'b1;
    t_en = cyc;
    wait_sd(1, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_sd: scan_done count %0d want 1", sd_cnt); end
    n_cmp++; if (st_ch.size() != 6) begin n_fail++; $display("FAIL basic_nstart: got %0d want 6", st_ch.size()); end
    for (int i = 0; i < 6 && i < st_ch.size(); i++) begin
      n_cmp++; if (st_ch[i] != ch_tab[i]) begin n_fail++; $display("FAIL basic_chnnl%0d: got %0d want %0d", i, st_ch[i], ch_tab[i]); end
    end
    if (st_cyc.size() > 0) begin
      n_cmp++; if (st_cyc[0] != t_en + 1) begin n_fail++; $display("FAIL basic_first_start: cycle %0d want %0d", st_cyc[0], t_en + 1); end
    end
    for (int i = 0; i + 1 < st_cyc.size(); i++) begin
      n_cmp++; if (st_cyc[i+1] - st_cyc[i] != 41) begin n_fail++; $display("FAIL basic_spacing%0d: got %0d want 41", i, st_cyc[i+1] - st_cyc[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      want = 12'(32'h111 * (i + 1));
      n_cmp++; if (pots[i] !== want) begin n_fail++; $display("FAIL basic_pot%0d: got %h want %h", i, pots[i], want); end
    end
    wait_starts(7, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_restart: starts %0d want 7", st_ch.size()); end
    if (ok) begin
      n_cmp++; if (st_cyc[6] - sd_cyc != SCAN_GAP) begin n_fail++; $display("FAIL basic_gap: got %0d want %0d", st_cyc[6] - sd_cyc, SCAN_GAP); end
      n_cmp++; if (st_cyc[6] - st_cyc[0] != 6 * 41 + SCAN_GAP) begin n_fail++; $display("FAIL basic_period: got %0d want %0d", st_cyc[6] - st_cyc[0], 6 * 41 + SCAN_GAP); end
      n_cmp++; if (st_ch[6] != 1) begin n_fail++; $display("FAIL basic_restart_ch: got %0d want 1", st_ch[6]); end
    end
    n_cmp++; if (sd_cnt != 1) begin n_fail++; $display("FAIL basic_sd_once: got %0d want 1", sd_cnt); end
    en = 1'b0;
  endtask

  task automatic test_smooth_random();
    bit ok;
    logic [11:0] want_lp [3];
    want_lp = '{12'h400, 12'h500, 12'h3C0};
    do_reset();
    vmode = 0; base_lat = 0; term_ch = -1; drop_mask = 8'h00;
    lp_vals = '{12'h400, 12'h800, 12'h000};
    lp_cnt  = 3;
    en = 1'b1;
    for (int s = 1; s <= 4; s++) begin
      wait_sd(s, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL smooth_sd%0d: count %0d", s, sd_cnt); end
      if (s <= 3) begin
        n_cmp++; if (pot_lp !== want_lp[s-1]) begin n_fail++; $display("FAIL smooth_lp%0d: got %h want %h", s, pot_lp, want_lp[s-1]); end
      end
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (pots[i] !== 12'(exp_pot[i])) begin n_fail++; $display("FAIL smooth_model s%0d pot%0d: got %h want %h", s, i, pots[i], 12'(exp_pot[i])); end
      end
    end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL smooth_err: got %b want 0", err); end
    en = 1'b0;
    lp_cnt = 0;
  endtask

  task automatic test_timeout();
    bit ok;
    logic [11:0] b2_snap;
    do_reset();
    vmode = 0; base_lat = 0; term_ch = -1; drop_mask = 8'h00;
    en = 1'b1;
    wait_sd(1, ok);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_pre: got %b want 0", err); end
    b2_snap   = pot_b2;
    drop_mask = 8'h10;
    wait_sd(2, ok);
    drop_mask = 8'h00;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL to_sd: count %0d want 2", sd_cnt); end
    if (st_ch.size() >= 10) begin
      n_cmp++; if (st_ch[8] != 4 || st_ch[9] != 2) begin n_fail++; $display("FAIL to_order: got %0d,%0d want 4,2", st_ch[8], st_ch[9]); end
      n_cmp++; if (st_cyc[9] - st_cyc[8] != TIMEOUT + 1) begin n_fail++; $display("FAIL to_len: got %0d want %0d", st_cyc[9] - st_cyc[8], TIMEOUT + 1); end
    end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err); end
    n_cmp++; if (pot_b2 !== b2_snap) begin n_fail++; $display("FAIL to_b2_hold: got %h want %h", pot_b2, b2_snap); end
    wait_sd(3, ok);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", err); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (pots[i] !== 12'(exp_pot[i])) begin n_fail++; $display("FAIL to_model pot%0d: got %h want %h", i, pots[i], 12'(exp_pot[i])); end
    end
    en = 1'b0;
  endtask

  task automatic test_terminal_and_spurious();
    bit ok;
    logic [11:0] snap [6];
    do_reset();
    vmode = 0; base_lat = 0; drop_mask = 8'h00;
    term_ch = 3;
    en = 1'b1;
    wait_sd(1, ok);
    en = 1'b0;
    term_ch = -1;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL tc_sd: count %0d want 1", sd_cnt); end
    if (st_cyc.size() >= 6) begin
      n_cmp++; if (st_cyc[5] - st_cyc[4] != TIMEOUT + 1) begin n_fail++; $display("FAIL tc_len: got %0d want %0d", st_cyc[5] - st_cyc[4], TIMEOUT + 1); end
    end
    n_cmp++; if (pot_hp !== 12'(exp_pot[4]) || !exp_seen[4]) begin n_fail++; $display("FAIL tc_value: got %h want %h", pot_hp, 12'(exp_pot[4])); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL tc_err: got %b want 0", err); end
    for (int i = 0; i < 6; i++) snap[i] = pots[i];
    spur_cnt++;
    repeat (5) @(negedge clk);
    n_cmp++; if (spur_cnt != spur_done) begin n_fail++; $display("FAIL spur_sent: done %0d want %0d", spur_done, spur_cnt); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (pots[i] !== snap[i]) begin n_fail++; $display("FAIL spur_pot%0d: got %h want %h", i, pots[i], snap[i]); end
    end
    n_cmp++; if (st_ch.size() != 6) begin n_fail++; $display("FAIL spur_start: starts %0d want 6", st_ch.size()); end
  endtask

  task automatic test_en_drop();
    bit ok;
    do_reset();
    vmode = 0; base_lat = 0; term_ch = -1; drop_mask = 8'h00;
    en = 1'b1;
    wait_starts(3, ok);
    en = 1'b0;
    wait_sd(1, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL endrop_sd: count %0d want 1", sd_cnt); end
    n_cmp++; if (st_ch.size() != 6 || st_ch[st_ch.size()-1] != 7) begin n_fail++; $display("FAIL endrop_last: starts %0d want 6 ending ch7", st_ch.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (pots[i] !== 12'(exp_pot[i])) begin n_fail++; $display("FAIL endrop_model pot%0d: got %h want %h", i, pots[i], 12'(exp_pot[i])); end
    end
    repeat (SCAN_GAP + 100) @(negedge clk);
    n_cmp++; if (st_ch.size() != 6) begin n_fail++; $display("FAIL endrop_idle: starts %0d want 6", st_ch.size()); end
    n_cmp++; if (sd_cnt != 1) begin n_fail++; $display("FAIL endrop_sd_once: got %0d want 1", sd_cnt); end
  endtask

  task automatic test_rst_mid_wait();
    bit ok;
    do_reset();
    vmode = 0; base_lat = 40; term_ch = -1; drop_mask = 8'h10;
    en = 1'b1;
    wait_starts(4, ok);
    repeat (10) @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL rstw_err_pre: got %b want 1", err); end
    rst = 1'b1;
    en  = 1'b0;
    #1;
    n_cmp++; if (a2d.strt_cnv !== 1'b0 || a2d.chnnl !== 3'd1) begin n_fail++; $display("FAIL rstw_bus: strt %b chnnl %0d want 0/1", a2d.strt_cnv, a2d.chnnl); end
    n_cmp++; if (err !== 1'b0 || scan_done !== 1'b0) begin n_fail++; $display("FAIL rstw_flags: err %b sd %b want 0/0", err, scan_done); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (pots[i] !== 12'h000) begin n_fail++; $display("FAIL rstw_pot%0d: got %h want 000", i, pots[i]); end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drop_mask = 8'h00;
    for (int k = 0; k < 300 && pend; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++; if (pend !== 1'b0) begin n_fail++; $display("FAIL rstw_late_sent: pending %b want 0", pend); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (pots[i] !== 12'h000) begin n_fail++; $display("FAIL rstw_late_pot%0d: got %h want 000", i, pots[i]); end
    end
    base_lat = 0;
    en = 1'b1;
    wait_sd(1, ok);
    en = 1'b0;
    n_cmp++; if (!ok || st_ch.size() < 1 || st_ch[0] != 1) begin n_fail++; $display("FAIL rstw_restart: sd %0d starts %0d want ch1 first", sd_cnt, st_ch.size()); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (pots[i] !== 12'(exp_pot[i])) begin n_fail++; $display("FAIL rstw_model pot%0d: got %h want %h", i, pots[i], 12'(exp_pot[i])); end
    end
  endtask

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_basic_scan();
    test_smooth_random();
    test_timeout();
    test_terminal_and_spurious();
    test_en_drop();
    test_rst_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pot_scan_ctrl.md
# pot_scan_ctrl

Sequencing controller for the slide-potentiometer A2D path of the equalizer. It drives the shared SPI A2D transactor (strt_cnv/cnv_cmplt handshake) round-robin across the six pot channels of the ADC128S, optionally smooths each result, and holds the latest 12-bit value per pot. Those values feed the band-gain and volume stages. It also flags a transactor that never completes.

## Interface
- SCAN_GAP, 1024: idle cycles between the end of one full scan and the start of the next.
- TIMEOUT, 4096: max cycles in WAIT for cnv_cmplt before the channel is skipped.
- SMOOTH, 0: IIR shift; 0 = direct load, N = pot += (res − pot) >>> N.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; one clock, asynchronous, active-high.
- en  in  1  scanning enable, level-sensitive.
- strt_cnv  out  1  one-cycle request to the A2D transactor.
- chnnl  out  3  ADC channel for the current conversion.
- cnv_cmplt  in  1  one-cycle completion pulse from the transactor.
- res  in  12  conversion result, valid while cnv_cmplt = 1.
- POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, VOLUME  out  12 each  latest per-pot values.
- scan_done  out  1  one-cycle pulse after the sixth channel of a scan.
- err  out  1  sticky timeout flag.

## Operation
- Scan order is fixed, idx 0..5: POT_LP→ch1, POT_B1→ch0, POT_B2→ch4, POT_B3→ch2, POT_HP→ch3, VOLUME→ch7.
- FSM states are IDLE, START, WAIT and GAP.
  - IDLE: when en = 1, load idx = 0 and go to START.
  - START: strt_cnv = 1 for this single cycle, then go to WAIT unconditionally.
  - WAIT: the timer counts up.
    - If cnv_cmplt = 1, update pot[idx] and advance.
    - If the timer reaches TIMEOUT − 1 without cnv_cmplt, set err, leave pot[idx] unchanged, and advance.
  - Advance: if idx < 5, increment idx and go to START. If idx = 5, pulse scan_done and go to GAP.
  - GAP: count SCAN_GAP cycles. Then go to START with idx = 0 if en = 1, otherwise to IDLE.
- en = 0 mid-scan: the current scan completes, including any pending WAIT, then GAP, then IDLE. en is sampled only in IDLE and at GAP exit.
- chnnl is held stable from START until the WAIT exit.
- cnv_cmplt outside WAIT is ignored.
- Smoothing:
  - A per-pot "seen" bit is cleared by rst. The first valid result after reset loads directly.
  - Later updates use diff = {1'b0,res} − {1'b0,pot}, a 13-bit signed value. The new pot = pot + (diff >>> SMOOTH), truncated to 12 bits. The result cannot overflow because |diff>>>N| ≤ |diff|.
- err clears only on rst.

## Timing
- Reset values: state IDLE, idx 0, strt_cnv 0, chnnl 3'd1, all pots 12'h000, scan_done 0, err 0, seen bits 0.
- en high at edge k → START (strt_cnv high) during cycle k+1. The transactor must accept a one-cycle strt_cnv.
- cnv_cmplt high in cycle c → pot register updated at edge c+1. scan_done (for idx 5) is high in cycle c+1. Next START is in cycle c+1 for idx < 5.
- Timeout: with no cnv_cmplt, WAIT lasts exactly TIMEOUT cycles.
- cnv_cmplt in the same cycle as the timeout terminal count counts as completion; err is not set.
- Full scan period with an ideal transactor of latency L (START→cnv_cmplt) = 6·(L+1) + SCAN_GAP cycles.
- rst asserted mid-WAIT returns every output to its reset value immediately. A late cnv_cmplt after rst release is ignored because the FSM is in IDLE.

## Structure
- Package eq_pkg holds:
  - the scan_state_t enum {IDLE, START, WAIT, GAP};
  - NUM_POTS = 6;
  - the CH_MAP constant array {1,0,4,2,3,7};
  - pot index localparams.
- One sub-module: pot_timer, a clearable up-counter with a terminal-count compare. It is shared between the WAIT timeout and the GAP count and is cleared on every state entry.
- The pot registers, seen bits and smoothing adder stay in the top level as a single shared 13-bit subtract/shift path indexed by idx.

## Test plan
- Reset then en = 1; the transactor model returns 12'h111·(idx+1) after 40 cycles → chnnl sequence 1,0,4,2,3,7. Pots hold 111,222,333,444,555,666 (hex). scan_done pulses once. The next strt_cnv comes exactly SCAN_GAP cycles later.
- SMOOTH = 2, POT_LP samples 12'h400 then 12'h800 → 12'h400, then 12'h500. Then 12'h000 → 12'h3C0.
- Model never answers ch4 → WAIT lasts TIMEOUT cycles, err = 1, POT_B2 unchanged, scan continues to ch2. err stays 1 through later good scans.
- cnv_cmplt on the exact terminal-count cycle → value stored, err = 0. A spurious cnv_cmplt during GAP → no pot change.
- en dropped during idx 2 → scan completes through VOLUME, scan_done pulses, GAP, then IDLE. No further strt_cnv.
- rst pulse during WAIT at idx 3 → all pots 12'h000, strt_cnv 0, err 0. After release with en = 1, the scan restarts at ch1.
